// File: rtl/instr_fetch.sv
// Instruction fetch: owns the 22-bit PC, issues imem word requests and buffers returned words in an in-order prefetch FIFO.
// Optional: define IF_STATIC_PREDICT_EN to predict-taken on returning B/JAL words.
module instr_fetch #(
    parameter logic [21:0] RESET_PC        = 22'h000000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [21:0] redirect_pc,
    input  logic        hlt,
    output logic        imem_req,
    output logic [21:0] imem_addr,
    input  logic        imem_rdy,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [21:0] PC_out,
    output logic        instr_valid,
    output logic        halted
);

    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OUT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TAG_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned TAG_DEPTH = 1 << TAG_W;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t           state;
    logic [21:0]      fetch_pc;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] drop_cnt;
    logic [OUT_W-1:0] out_next;

    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [21:0]      fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [21:0]      tag_pc [TAG_DEPTH];
    logic [TAG_W-1:0] tag_rd;
    logic [TAG_W-1:0] tag_wr;

    logic credit_ok;
    logic accept;
    logic resp;
    logic push;
    logic pop;
    logic redirect_take;
    logic hlt_take;
    logic predict_take;

    assign redirect_take = redirect_valid && (state != ST_HALT);
    assign hlt_take      = hlt && !redirect_valid && (state != ST_HALT);

    // Credit: every in-flight request must have a FIFO slot reserved for its response
    assign credit_ok = ((32'(outstanding) + 32'(count)) < FIFO_DEPTH) &&
                       (32'(outstanding) < MAX_OUTSTANDING);

    // No request while reset is held, nor in a redirect or halt cycle
    assign imem_req  = rst_n && (state == ST_RUN) && credit_ok && !redirect_valid && !hlt;
    assign imem_addr = fetch_pc;

    assign accept   = imem_req && imem_rdy;
    assign resp     = imem_rvalid && (outstanding != '0);
    assign push     = resp && (drop_cnt == '0) && (state != ST_HALT) && !redirect_valid && !hlt_take;
    assign pop      = instr_valid && !stall;
    assign out_next = outstanding + OUT_W'(accept) - OUT_W'(resp);

`ifdef IF_STATIC_PREDICT_EN
    assign predict_take = push && ((imem_rdata[31:27] == 5'b01110) || (imem_rdata[31:27] == 5'b10001));
`else
    assign predict_take = 1'b0;
`endif

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? fifo_instr[rd_ptr] : 32'h0;
    assign PC_out      = instr_valid ? fifo_pc[rd_ptr] : 22'h0;

    // PC, in-flight accounting and run/drain/halt control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            halted      <= 1'b0;
        end else begin
            outstanding <= out_next;
            if (accept) begin
                fetch_pc <= fetch_pc + 22'd1;
            end
            if (resp && !push && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - OUT_W'(1);
            end
            if (redirect_take) begin
                fetch_pc <= redirect_pc;
                drop_cnt <= out_next;
                state    <= (out_next != '0) ? ST_DRAIN : ST_RUN;
            end else if (hlt_take) begin
                state  <= ST_HALT;
                halted <= 1'b1;
            end else if (predict_take) begin
                fetch_pc <= imem_rdata[21:0];
                drop_cnt <= out_next;
                state    <= (out_next != '0) ? ST_DRAIN : ST_RUN;
            end else if ((state == ST_DRAIN) && resp && (drop_cnt == OUT_W'(1))) begin
                state <= ST_RUN;
            end
        end
    end

    // FIFO pointers; a halt keeps only a stalled head entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_take) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (hlt_take) begin
            wr_ptr <= (stall && instr_valid) ? rd_ptr + PTR_W'(1) : rd_ptr;
            count  <= CNT_W'(stall && instr_valid);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= tag_pc[tag_rd];
        end
    end

    // In-order PC tags for in-flight requests; every response retires one tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_rd <= '0;
            tag_wr <= '0;
        end else begin
            if (accept) begin
                tag_wr <= tag_wr + TAG_W'(1);
            end
            if (resp) begin
                tag_rd <= tag_rd + TAG_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_pc[tag_wr] <= fetch_pc;
        end
    end

    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count == CNT_W'(FIFO_DEPTH))));

endmodule
